// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch port, data port, flush and shared memory port seen by sram_port_arbiter.
// slave is the arbiter's view; master is the CPU/memory side that drives it.
interface sram_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_addr_ok;
   logic              i_data_ok;
   logic [DATA_W-1:0] i_rdata;
   logic              d_req;
   logic              d_wr;
   logic [1:0]        d_size;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_addr_ok;
   logic              d_data_ok;
   logic [DATA_W-1:0] d_rdata;
   logic              flush;
   logic              mem_req;
   logic              mem_wr;
   logic [1:0]        mem_size;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_addr_ok;
   logic              mem_data_ok;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_size, d_addr, d_wdata, flush,
      input  mem_addr_ok, mem_data_ok, mem_rdata,
      output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
      output mem_req, mem_wr, mem_size, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_size, d_addr, d_wdata, flush,
      output mem_addr_ok, mem_data_ok, mem_rdata,
      input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
      input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Arbitrates inst-fetch and data ports onto one SRAM-like port, one transaction in flight,
// dropping stale fetch responses after a flush. Define SRAM_ARB_RR_EN for round-robin contention.
module sram_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic                clk,
   input logic                reset,
   sram_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t state_r, state_nx;
   logic   owner_r, owner_nx;
   logic   drop_inst_r, drop_inst_nx;
   logic   pick_data_s;
   logic   sel_data_s;
   logic   fwd_s;
   logic   accept_s;

`ifdef SRAM_ARB_RR_EN
   logic   last_owner_r, last_owner_nx;

   // On contention the side that lost the last accepted transaction wins.
   assign pick_data_s = (bus.d_req && bus.i_req) ? ~last_owner_r : bus.d_req;
`else
   assign pick_data_s = bus.d_req;
`endif

   // State, owner and drop-flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         owner_r      <= 1'b0;
         drop_inst_r  <= 1'b0;
`ifdef SRAM_ARB_RR_EN
         last_owner_r <= 1'b0;
`endif
      end else begin
         state_r      <= state_nx;
         owner_r      <= owner_nx;
         drop_inst_r  <= drop_inst_nx;
`ifdef SRAM_ARB_RR_EN
         last_owner_r <= last_owner_nx;
`endif
      end
   end

   // Next-state logic, request forwarding and response routing.
   always_comb begin
      state_nx      = state_r;
      owner_nx      = owner_r;
      drop_inst_nx  = drop_inst_r;
`ifdef SRAM_ARB_RR_EN
      last_owner_nx = last_owner_r;
`endif
      sel_data_s    = 1'b0;
      fwd_s         = 1'b0;
      accept_s      = 1'b0;
      bus.i_addr_ok = 1'b0;
      bus.i_data_ok = 1'b0;
      bus.i_rdata   = {DATA_W{1'b0}};
      bus.d_addr_ok = 1'b0;
      bus.d_data_ok = 1'b0;
      bus.d_rdata   = {DATA_W{1'b0}};
      bus.mem_req   = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_size  = 2'd0;
      bus.mem_addr  = {ADDR_W{1'b0}};
      bus.mem_wdata = {DATA_W{1'b0}};

      if (reset) begin
         state_nx = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.d_req || bus.i_req) begin
                  sel_data_s = pick_data_s;
                  fwd_s      = 1'b1;
                  owner_nx   = pick_data_s;
                  if (bus.mem_addr_ok) begin
                     accept_s = 1'b1;
                     state_nx = ST_RESP;
                  end else begin
                     state_nx = ST_ADDR;
                  end
               end else begin
                  state_nx = ST_IDLE;
               end
            end
            ST_ADDR: begin
               sel_data_s = owner_r;
               fwd_s      = owner_r ? bus.d_req : bus.i_req;
               if (fwd_s && bus.mem_addr_ok) begin
                  accept_s = 1'b1;
                  state_nx = ST_RESP;
                  if (!owner_r && bus.flush) begin
                     drop_inst_nx = 1'b1;
                  end else begin
                     drop_inst_nx = drop_inst_r;
                  end
               end else if (!fwd_s || (!owner_r && bus.flush)) begin
                  // Owner withdrew or a flush abandoned an unaccepted fetch.
                  state_nx = ST_IDLE;
               end else begin
                  state_nx = ST_ADDR;
               end
            end
            ST_RESP: begin
               if (bus.mem_data_ok) begin
                  state_nx     = ST_IDLE;
                  drop_inst_nx = 1'b0;
                  if (owner_r) begin
                     bus.d_data_ok = 1'b1;
                     bus.d_rdata   = bus.mem_rdata;
                  end else if (!(drop_inst_r || bus.flush)) begin
                     bus.i_data_ok = 1'b1;
                     bus.i_rdata   = bus.mem_rdata;
                  end else begin
                     bus.i_data_ok = 1'b0;
                  end
               end else if (!owner_r && bus.flush) begin
                  drop_inst_nx = 1'b1;
               end else begin
                  drop_inst_nx = drop_inst_r;
               end
            end
            default: begin
               state_nx = ST_IDLE;
            end
         endcase

         if (fwd_s) begin
            bus.mem_req = 1'b1;
            if (sel_data_s) begin
               bus.mem_wr    = bus.d_wr;
               bus.mem_size  = bus.d_size;
               bus.mem_addr  = bus.d_addr;
               bus.mem_wdata = bus.d_wdata;
            end else begin
               bus.mem_wr    = 1'b0;
               bus.mem_size  = 2'd2;
               bus.mem_addr  = bus.i_addr;
               bus.mem_wdata = {DATA_W{1'b0}};
            end
         end else begin
            bus.mem_req = 1'b0;
         end

         if (accept_s) begin
            bus.d_addr_ok = sel_data_s;
            bus.i_addr_ok = ~sel_data_s;
`ifdef SRAM_ARB_RR_EN
            last_owner_nx = sel_data_s;
`endif
         end else begin
            bus.d_addr_ok = 1'b0;
            bus.i_addr_ok = 1'b0;
         end
      end
   end

endmodule
